// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: opcodes, FSM states
// and ALUFlags bit positions as consumed by the conditional-execution logic.
package mcycle_pkg;

    typedef enum logic [1:0] {
        MC_SMUL = 2'b00,
        MC_UMUL = 2'b01,
        MC_SDIV = 2'b10,
        MC_UDIV = 2'b11
    } mc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DONE    = 2'b10
    } mc_state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mcycle_step.sv
// One iteration of the unsigned datapath: shift-add multiply step or restoring
// shift-subtract divide step over the {hi, lo} register pair.
module mcycle_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] add;

    always_comb begin
        shifted = {hi_i, lo_i[WIDTH-1]};
        sum     = {1'b0, hi_i} + {1'b0, b_i};
        add     = lo_i[0] ? sum : {1'b0, hi_i};
        hi_o    = '0;
        lo_o    = '0;
        if (is_div_i) begin
            // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
            if (shifted >= {1'b0, b_i}) begin
                hi_o = WIDTH'(shifted - {1'b0, b_i});
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shifted[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Multiply: hi accumulates, lo shifts multiplier out and product low bits in.
            hi_o = add[WIDTH:1];
            lo_o = {add[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mcycle_muldiv.sv
// Iterative multiply/divide unit: Start/Busy handshake, WIDTH iterations, sign
// correction and {N,Z,C,V} flags registered together with the results.
module mcycle_muldiv
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic [3:0]       ALUFlags,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    mc_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   hi_n, lo_n;
    logic               in_div, in_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo, rem, fin1, fin2;
    logic               fin_z, fin_v;

    mcycle_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div_i(is_div_q),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .b_i     (b_q),
        .hi_o    (hi_n),
        .lo_o    (lo_n)
    );

    // Magnitudes and sign information of the incoming request.
    always_comb begin
        in_div    = op_is_div(MCOp);
        in_signed = op_is_signed(MCOp);
        sign_a    = in_signed & Operand1[WIDTH-1];
        sign_b    = in_signed & Operand2[WIDTH-1];
        mag_a     = sign_a ? -Operand1 : Operand1;
        mag_b     = sign_b ? -Operand2 : Operand2;
    end

    // Final iteration result with sign correction and the two divide exceptions.
    always_comb begin
        prod     = {hi_n, lo_n};
        prod_fix = neg_res_q ? -prod : prod;
        quo      = neg_res_q ? -lo_n : lo_n;
        rem      = neg_rem_q ? -hi_n : hi_n;
        fin1     = prod_fix[WIDTH-1:0];
        fin2     = prod_fix[2*WIDTH-1:WIDTH];
        fin_v    = 1'b0;
        fin_z    = (prod_fix == '0);
        if (is_div_q) begin
            if (div0_q) begin
                fin1  = '1;
                fin2  = op1_q;
                fin_v = 1'b1;
            end else if (ovf_q) begin
                fin1  = MIN_VAL;
                fin2  = '0;
                fin_v = 1'b1;
            end else begin
                fin1 = quo;
                fin2 = rem;
            end
            fin_z = (fin1 == '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op1_d     = op1_q;
        res1_d    = res1_q;
        res2_d    = res2_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d   = ST_COMPUTE;
                    cnt_d     = '0;
                    is_div_d  = in_div;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div0_d    = in_div & (Operand2 == '0);
                    ovf_d     = in_div & in_signed & (Operand1 == MIN_VAL) & (Operand2 == '1);
                    hi_d      = '0;
                    lo_d      = in_div ? mag_a : mag_b;
                    b_d       = in_div ? mag_b : mag_a;
                    op1_d     = Operand1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d         = ST_DONE;
                    done_d          = 1'b1;
                    res1_d          = fin1;
                    res2_d          = fin2;
                    flags_d         = '0;
                    flags_d[FLAG_N] = fin1[WIDTH-1];
                    flags_d[FLAG_Z] = fin_z;
                    flags_d[FLAG_C] = 1'b0;
                    flags_d[FLAG_V] = fin_v;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op1_q     <= '0;
            res1_q    <= '0;
            res2_q    <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op1_q     <= op1_d;
            res1_q    <= res1_d;
            res2_q    <= res2_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign Busy     = ((state_q != ST_COMPUTE) && Start) || (state_q == ST_COMPUTE);
    assign Done     = done_q;
    assign Result1  = res1_q;
    assign Result2  = res2_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Bench for mcycle_muldiv: directed cases followed by random operations, all
// checked against an arithmetic reference model.
module tb_mcycle_muldiv;

    localparam logic [1:0] SMUL = 2'b00;
    localparam logic [1:0] UMUL = 2'b01;
    localparam logic [1:0] SDIV = 2'b10;
    localparam logic [1:0] UDIV = 2'b11;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [1:0]  MCOp;
    logic [31:0] Operand1, Operand2;
    logic [31:0] Result1, Result2;
    logic [3:0]  ALUFlags;
    logic        Busy, Done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_r1, exp_r2;
    logic [3:0]  exp_fl;

    always #5 CLK = ~CLK;

    mcycle_muldiv #(
        .WIDTH(32)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Start   (Start),
        .MCOp    (MCOp),
        .Operand1(Operand1),
        .Operand2(Operand2),
        .Result1 (Result1),
        .Result2 (Result2),
        .ALUFlags(ALUFlags),
        .Busy    (Busy),
        .Done    (Done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: plain integer arithmetic, truncating signed division.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb;
        logic        v;
        sa = int'(a);
        sb = int'(b);
        v  = 1'b0;
        case (op)
            SMUL: begin
                p = longint'(sa) * longint'(sb);
                {exp_r2, exp_r1} = p;
            end
            UMUL: begin
                p = {32'h0, a} * {32'h0, b};
                {exp_r2, exp_r1} = p;
            end
            default: begin
                if (b == 32'h0) begin
                    exp_r1 = 32'hFFFF_FFFF;
                    exp_r2 = a;
                    v      = 1'b1;
                end else if (op == SDIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    exp_r1 = 32'h8000_0000;
                    exp_r2 = 32'h0;
                    v      = 1'b1;
                end else if (op == SDIV) begin
                    exp_r1 = 32'(sa / sb);
                    exp_r2 = 32'(sa % sb);
                end else begin
                    exp_r1 = a / b;
                    exp_r2 = a % b;
                end
            end
        endcase
        if (op[1]) exp_fl = {exp_r1[31], exp_r1 == 32'h0, 1'b0, v};
        else       exp_fl = {exp_r1[31], (exp_r1 == 32'h0) && (exp_r2 == 32'h0), 1'b0, v};
    endtask

    // Present a request in a non-computing cycle; returns in the first compute cycle
    // with the inputs scrambled so that only the latched values can matter.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        model(op, a, b);
        MCOp     = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        #1;
        chk("busy_on_start", 32'(Busy), 32'd1);
        tick();
        Start    = 1'b0;
        MCOp     = 2'($urandom);
        Operand1 = $urandom;
        Operand2 = 32'h0;
    endtask

    // Expects exactly 32 busy cycles, then checks the Done cycle; returns in it.
    task automatic wait_done(input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0) bad = 1'b1;
            if (i == 3) Start = 1'b1;
            if (i == 4) Start = 1'b0;
            tick();
        end
        chk({tag, "_busy_window"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_busy_low"}, 32'(Busy), 32'd0);
        chk({tag, "_r1"}, Result1, exp_r1);
        chk({tag, "_r2"}, Result2, exp_r2);
        chk({tag, "_flags"}, 32'(ALUFlags), 32'(exp_fl));
    endtask

    task automatic idle_after(input string tag);
        tick();
        chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
        chk({tag, "_hold_r1"}, Result1, exp_r1);
    endtask

    initial begin
        logic        bad;
        logic [1:0]  op;
        logic [31:0] a, b;
        RESET    = 1'b1;
        Start    = 1'b0;
        MCOp     = 2'b00;
        Operand1 = 32'h0;
        Operand2 = 32'h0;
        tick();
        tick();
        chk("rst_r1", Result1, 32'h0);
        chk("rst_r2", Result2, 32'h0);
        chk("rst_flags", 32'(ALUFlags), 32'h0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        RESET = 1'b0;
        tick();

        start_op(UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("umul_max");
        chk("umul_max_r2_const", Result2, 32'hFFFF_FFFE);
        idle_after("umul_max");

        start_op(SMUL, 32'hFFFF_FFFD, 32'd5);
        wait_done("smul_m3x5");
        chk("smul_m3x5_r1_const", Result1, 32'hFFFF_FFF1);
        idle_after("smul_m3x5");

        start_op(SDIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("sdiv_m7d2");
        start_op(UDIV, 32'd9, 32'd3);
        wait_done("udiv_b2b");
        chk("udiv_b2b_q_const", Result1, 32'd3);
        idle_after("udiv_b2b");

        start_op(UDIV, 32'd100, 32'd0);
        wait_done("udiv_by0");
        chk("udiv_by0_flags_const", 32'(ALUFlags), 32'h9);
        idle_after("udiv_by0");

        start_op(SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("sdiv_ovf");
        idle_after("sdiv_ovf");

        start_op(SDIV, 32'hFFFF_FFFB, 32'd0);
        wait_done("sdiv_by0");
        idle_after("sdiv_by0");

        start_op(UMUL, 32'd0, 32'd12345);
        wait_done("umul_zero");
        idle_after("umul_zero");

        start_op(UMUL, 32'h0001_0000, 32'h0001_0000);
        wait_done("umul_2p32");
        idle_after("umul_2p32");

        // Reset in the middle of a multiply.
        start_op(UMUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_r1", Result1, 32'h0);
        chk("abort_r2", Result2, 32'h0);
        chk("abort_flags", 32'(ALUFlags), 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("abort_no_late_done", 32'(bad), 32'd0);
        start_op(UMUL, 32'd7, 32'd6);
        wait_done("after_abort");
        idle_after("after_abort");

        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            start_op(op, a, b);
            wait_done("rand");
            if ($urandom_range(0, 1) == 0) idle_after("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_muldiv.md
Name: mcycle_muldiv

Overview:
- Iterative multi-cycle multiply/divide unit for the ARM core. It is the producer side of the condition-flag path.
- Accepts an operation with a Start/Busy handshake and computes a 2*WIDTH product or a quotient/remainder over WIDTH iterations.
- Returns results plus an ALUFlags nibble {N,Z,C,V} in the same encoding the conditional-execution logic consumes.
- Sits beside the ALU. The control path stalls the pipeline while Busy is high.

Parameters:
- WIDTH, 32, operand/result word width (>=4).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only when the unit is not computing.
- MCOp  input  2  00 signed MUL, 01 unsigned MUL, 10 signed DIV, 11 unsigned DIV.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  MUL: low product word. DIV: quotient.
- Result2  output  WIDTH  MUL: high product word. DIV: remainder.
- ALUFlags  output  4  {N,Z,C,V} for the completed op.
- Busy  output  1  stall request, combinational.
- Done  output  1  one-cycle completion pulse, registered.

Behaviour:
- Reset values: Result1=0, Result2=0, ALUFlags=0, Done=0, Busy=0. State goes to IDLE and the iteration counter to 0.
- States: IDLE, COMPUTE, DONE.
- Busy = (state!=COMPUTE & Start) | (state==COMPUTE).
- Acceptance: Start=1 in IDLE or DONE at edge t.
  - MCOp and operands are latched at that edge.
  - For signed ops the operand magnitudes and result signs are latched too.
- State goes to COMPUTE for exactly WIDTH cycles (counter 0..WIDTH-1), one iteration per cycle.
  - MUL: shift-add on unsigned magnitudes into a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract on unsigned magnitudes.
- Completion at edge t+WIDTH+1:
  - Sign correction is applied.
  - Result1, Result2 and ALUFlags are registered together.
  - State goes to DONE; Done=1 and Busy=0 for that one cycle (unless Start re-asserts).
- DONE goes to IDLE on the next edge, or straight to COMPUTE if Start=1 (back-to-back accept, no bubble).
- Latency: Start at edge t gives Done high during cycle t+WIDTH+1. Busy is high from the Start cycle through the last COMPUTE cycle.
- Outputs hold their values until the next completion. An accepted Start does not clear them.
- Start, MCOp and operand changes during COMPUTE are ignored; the latched values are used.
- Signed MUL: product is negated iff operand signs differ.
- Signed DIV:
  - Quotient is negated iff signs differ.
  - Remainder takes the sign of the dividend (truncating division).
- Flags:
  - N = Result1[WIDTH-1].
  - Z = (Result1==0); for MUL this must also include Result2==0.
  - C = 0 always.
  - V = 0 except for the two DIV exceptions below.
- Divide by zero (any DIV): Result1=all ones, Result2=Operand1 as latched, V=1. Latency is still the full WIDTH+1.
- Signed overflow, MIN / -1: Result1=MIN, Result2=0, V=1. The natural magnitude path already yields this; V is forced.
- RESET during COMPUTE:
  - Aborts the operation; no Done for it.
  - All outputs return to reset values on that edge.
  - Start is accepted on the first cycle after RESET deasserts.
- RESET has priority over Start on the same edge.

Decomposition:
- Shared package mcycle_pkg holds:
  - MCOp encodings: MC_SMUL, MC_UMUL, MC_SDIV, MC_UDIV.
  - State encodings: ST_IDLE, ST_COMPUTE, ST_DONE.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module is natural: mcycle_step.
  - Purely combinational single-iteration datapath.
  - Inputs: accumulator and shift registers. Outputs: next values, selected by op.
  - The top holds the FSM, counter, sign handling and output registers.

Test Plan:
- WIDTH=32, UMUL 0xFFFFFFFF x 0xFFFFFFFF, Start at t -> Busy 1 for t..t+32, Done at t+33, Result2=0xFFFFFFFE, Result1=0x00000001, ALUFlags=0000.
- SMUL -3 x 5 -> Result1=0xFFFFFFF1, Result2=0xFFFFFFFF, ALUFlags=1000. Operands changed to 0 mid-op do not alter the result.
- SDIV -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF, ALUFlags=1000.
  - Then Start held during the Done cycle with UDIV 9/3 -> accepted immediately; next Done gives Result1=3, Result2=0, ALUFlags=0000.
- UDIV 100 / 0 -> Result1=0xFFFFFFFF, Result2=100, ALUFlags=1001. SDIV 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0, ALUFlags=1001.
- UMUL 0 x 12345 -> all results 0, ALUFlags=0100. UMUL 0x10000 x 0x10000 -> Result1=0, Result2=1, Z=0.
- RESET asserted at t+10 of a UMUL -> next cycle Busy=0, Done=0, results 0, no late Done. Start at the following cycle completes normally in 33 cycles.
